// File: rtl/io_switch_led.sv
// ============================================================================
// io_switch_led
// ----------------------------------------------------------------------------
// Memory-mapped LED / switch peripheral for the single-cycle MIPS core. It sits
// directly behind MemOrIO: LED writes land in a 24-bit output register, and
// switch reads return a synchronised, debounced copy of the 24 board switches.
//
// Ports
//   clock       in   1   cpu clock, all state updates on posedge
//   reset       in   1   synchronous, active-high reset
//   led_ctrl    in   1   LED chip select from MemOrIO
//   switch_ctrl in   1   switch chip select from MemOrIO
//   io_read     in   1   IORead strobe
//   io_write    in   1   IOWrite strobe
//   addr        in   2   low address bits: 2'b00 low halfword, 2'b10 high byte
//   wdata       in  16   write data
//   rdata       out 16   read data back to MemOrIO (combinational)
//   switch_i    in  24   raw board switches (asynchronous)
//   led_o       out 24   board LEDs (registered)
//
// Bus semantics: there is no valid/ready handshake. A chip select qualified by
// io_write commits on the next rising edge; a chip select qualified by io_read
// returns data combinationally in the same cycle. The core never stalls, so
// every access completes in exactly one cycle.
//
// Build option
//   IO_LED_READBACK_EN  when defined, an LED chip select with io_read returns
//                       the current LED register contents. When undefined,
//                       LED reads return zero and no readback mux exists.
// ============================================================================
module io_switch_led #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DEB_CNT_W       = 20
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        led_ctrl,
    input  logic        switch_ctrl,
    input  logic        io_read,
    input  logic        io_write,
    input  logic [1:0]  addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    input  logic [23:0] switch_i,
    output logic [23:0] led_o
);

    localparam logic [1:0] ADDR_LO = 2'b00;
    localparam logic [1:0] ADDR_HI = 2'b10;

    // Terminal count: the debounced value updates on the cycle the counter
    // sits at DEBOUNCE_CYCLES-1 with the input still stable.
    localparam logic [DEB_CNT_W-1:0] CNT_LAST = DEB_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DEB_CNT_W-1:0] CNT_ONE  = DEB_CNT_W'(1);

    // ------------------------------------------------------------------------
    // LED register
    // ------------------------------------------------------------------------
    logic led_wr;

    assign led_wr = led_ctrl && io_write;

    always_ff @(posedge clock) begin
        if (reset) begin
            led_o <= 24'h000000;
        end else if (led_wr) begin
            case (addr)
                ADDR_LO: led_o[15:0]  <= wdata;
                // Only the low byte of the write data maps onto LEDs 23:16.
                ADDR_HI: led_o[23:16] <= wdata[7:0];
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Switch synchroniser
    // sync1/sync2 form a two-flop synchroniser for the asynchronous switches.
    // prev holds the previous synchronised sample so the debouncer can see
    // any bit change, including one that reverts before the count expires.
    // ------------------------------------------------------------------------
    logic [23:0] sync1;
    logic [23:0] sync2;
    logic [23:0] prev;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= 24'h000000;
            sync2 <= 24'h000000;
            prev  <= 24'h000000;
        end else begin
            sync1 <= switch_i;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // ------------------------------------------------------------------------
    // Debouncer
    // The whole 24-bit vector shares one counter. Priority order:
    //   1. input moved since last cycle      -> restart count
    //   2. input equals debounced value      -> nothing pending, hold at 0
    //   3. stable long enough                -> accept new value, clear count
    //   4. otherwise                         -> keep counting
    // ------------------------------------------------------------------------
    logic [23:0]          deb;
    logic [23:0]          deb_next;
    logic [DEB_CNT_W-1:0] cnt;
    logic [DEB_CNT_W-1:0] cnt_next;

    always_comb begin
        deb_next = deb;
        cnt_next = cnt;
        if (sync2 != prev) begin
            cnt_next = '0;
        end else if (sync2 == deb) begin
            cnt_next = '0;
        end else if (cnt == CNT_LAST) begin
            deb_next = sync2;
            cnt_next = '0;
        end else begin
            cnt_next = cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            deb <= 24'h000000;
            cnt <= '0;
        end else begin
            deb <= deb_next;
            cnt <= cnt_next;
        end
    end

    // ------------------------------------------------------------------------
    // Read path (combinational)
    // Reads see the register values from before the coming edge, so a read
    // issued in the same cycle as a write returns the old contents.
    // ------------------------------------------------------------------------
    logic        sw_rd;
    logic [15:0] sw_word;

    assign sw_rd = switch_ctrl && io_read;

    always_comb begin
        sw_word = 16'h0000;
        case (addr)
            ADDR_LO: sw_word = deb[15:0];
            ADDR_HI: sw_word = {8'h00, deb[23:16]};
            default: sw_word = 16'h0000;
        endcase
    end

`ifdef IO_LED_READBACK_EN
    logic        led_rd;
    logic [15:0] led_word;

    assign led_rd = led_ctrl && io_read;

    always_comb begin
        led_word = 16'h0000;
        case (addr)
            ADDR_LO: led_word = led_o[15:0];
            ADDR_HI: led_word = {8'h00, led_o[23:16]};
            default: led_word = 16'h0000;
        endcase
    end

    // Switch data wins if both chip selects are asserted together.
    always_comb begin
        rdata = 16'h0000;
        if (sw_rd) begin
            rdata = sw_word;
        end else if (led_rd) begin
            rdata = led_word;
        end
    end
`else
    always_comb begin
        rdata = 16'h0000;
        if (sw_rd) begin
            rdata = sw_word;
        end
    end
`endif

endmodule

// File: tb/tb_io_switch_led.sv
// ============================================================================
// tb_io_switch_led
// Directed bench for io_switch_led with a short debounce window
// (DEBOUNCE_CYCLES = 4), so a held switch change lands on the 7th edge.
// ============================================================================
module tb_io_switch_led;

    localparam int DEB_CYC = 4;

    // ---------------- clock / reset ----------------
    logic        clock;
    logic        reset;
    logic        led_ctrl;
    logic        switch_ctrl;
    logic        io_read;
    logic        io_write;
    logic [1:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic [23:0] switch_i;
    logic [23:0] led_o;

    int vectors;
    int miscompares;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    io_switch_led #(
        .DEBOUNCE_CYCLES (DEB_CYC),
        .DEB_CNT_W       (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .led_ctrl    (led_ctrl),
        .switch_ctrl (switch_ctrl),
        .io_read     (io_read),
        .io_write    (io_write),
        .addr        (addr),
        .wdata       (wdata),
        .rdata       (rdata),
        .switch_i    (switch_i),
        .led_o       (led_o)
    );

    // ---------------- driver tasks ----------------
    // Advance one rising edge, then settle 1 time unit past it so inputs
    // driven afterwards are stable well before the next edge and outputs
    // sampled here reflect the edge that just happened.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_bus();
        led_ctrl    = 1'b0;
        switch_ctrl = 1'b0;
        io_read     = 1'b0;
        io_write    = 1'b0;
        addr        = 2'b00;
        wdata       = 16'h0000;
    endtask

    task automatic sw_read(input logic [1:0] a);
        switch_ctrl = 1'b1;
        io_read     = 1'b1;
        addr        = a;
        #1;
    endtask

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [15:0] led_rd_exp;

    initial begin
        vectors     = 0;
        miscompares = 0;
        idle_bus();
        reset    = 1'b1;
        switch_i = 24'hFFFFFF;

        // 1. reset with switches all high
        repeat (2) tick();
        check("reset_led", led_o, 24'h000000);
        check("reset_rdata_idle", {8'h00, rdata}, 24'h000000);
        sw_read(2'b00);
        check("reset_sw_lo", {8'h00, rdata}, 24'h000000);
        sw_read(2'b10);
        check("reset_sw_hi", {8'h00, rdata}, 24'h000000);
        idle_bus();
        reset = 1'b0;

        // 2. LED writes
        led_ctrl = 1'b1; io_write = 1'b1; addr = 2'b00; wdata = 16'hA5C3;
        tick();
        check("led_wr_lo", led_o, 24'h00A5C3);
        addr = 2'b10; wdata = 16'h1234;
        tick();
        check("led_wr_hi", led_o, 24'h34A5C3);
        addr = 2'b01; wdata = 16'hFFFF;
        tick();
        check("led_wr_a01", led_o, 24'h34A5C3);
        addr = 2'b11; wdata = 16'hFFFF;
        tick();
        check("led_wr_a11", led_o, 24'h34A5C3);
        led_ctrl = 1'b0; switch_ctrl = 1'b1; addr = 2'b00; wdata = 16'h0000;
        tick();
        check("led_wr_no_cs", led_o, 24'h34A5C3);
        idle_bus();

        // 3. stable switch change lands on the 7th edge
        switch_i = 24'h000000;
        repeat (20) tick();
        sw_read(2'b00);
        check("sw_settled_zero", {8'h00, rdata}, 24'h000000);
        switch_i = 24'h5A0F0F;
        repeat (DEB_CYC + 2) tick();
        check("sw_edge6_old", {8'h00, rdata}, 24'h000000);
        tick();
        check("sw_edge7_lo", {8'h00, rdata}, 24'h000F0F);
        sw_read(2'b10);
        check("sw_edge7_hi", {8'h00, rdata}, 24'h00005A);
        sw_read(2'b01);
        check("sw_rd_a01", {8'h00, rdata}, 24'h000000);
        sw_read(2'b11);
        check("sw_rd_a11", {8'h00, rdata}, 24'h000000);
        io_read = 1'b0; addr = 2'b00; #1;
        check("sw_no_ioread", {8'h00, rdata}, 24'h000000);
        idle_bus();

        // 4. short glitch never reaches the debounced value
        switch_i = 24'h000000;
        repeat (10) tick();
        sw_read(2'b00);
        check("glitch_pre", {8'h00, rdata}, 24'h000000);
        switch_i = 24'h000001;
        repeat (3) tick();
        switch_i = 24'h000000;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("glitch_hold", {8'h00, rdata}, 24'h000000);
        end

        // 5. reset in the middle of a pending change
        switch_i = 24'h000F00;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset_sw", {8'h00, rdata}, 24'h000000);
        check("midreset_led", led_o, 24'h000000);
        repeat (DEB_CYC + 2) tick();
        check("midreset_edge6", {8'h00, rdata}, 24'h000000);
        tick();
        check("midreset_edge7", {8'h00, rdata}, 24'h000F00);
        idle_bus();

        // 6. LED readback (zero when the readback option is not built)
        led_ctrl = 1'b1; io_write = 1'b1; addr = 2'b00; wdata = 16'hBEEF;
        tick();
        addr = 2'b10; wdata = 16'hAB77;
        tick();
        check("led_beef", led_o, 24'h77BEEF);
        io_write = 1'b0; io_read = 1'b1; addr = 2'b00; #1;
`ifdef IO_LED_READBACK_EN
        led_rd_exp = 16'hBEEF;
`else
        led_rd_exp = 16'h0000;
`endif
        check("led_rd_lo", {8'h00, rdata}, {8'h00, led_rd_exp});
        addr = 2'b10; #1;
`ifdef IO_LED_READBACK_EN
        led_rd_exp = 16'h0077;
`else
        led_rd_exp = 16'h0000;
`endif
        check("led_rd_hi", {8'h00, rdata}, {8'h00, led_rd_exp});

        // read and write in the same cycle: read sees pre-edge value
        addr = 2'b00; io_write = 1'b1; wdata = 16'h1111; #1;
`ifdef IO_LED_READBACK_EN
        led_rd_exp = 16'hBEEF;
`else
        led_rd_exp = 16'h0000;
`endif
        check("led_rdwr_old", {8'h00, rdata}, {8'h00, led_rd_exp});
        tick();
        check("led_rdwr_new", led_o, 24'h771111);

        // both chip selects: switch read wins, LED write still lands
        switch_ctrl = 1'b1; wdata = 16'h2222; #1;
        check("both_cs_rd", {8'h00, rdata}, 24'h000F00);
        tick();
        check("both_cs_wr", led_o, 24'h772222);
        idle_bus();
        #1;
        check("idle_rdata", {8'h00, rdata}, 24'h000000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
